// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep controller and amplitude LUT.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dds_pkg;

  // Phase width is shared with the phase-to-amplitude LUT.
  localparam int PHASE_W = 10;
  localparam int DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dds_phase_acc.sv
// N-bit registered phase accumulator with synchronous clear and enable.
// Latency: one cycle from inc to phase; clear takes effect on the next edge.
// Backpressure: none; enable simply holds the phase.
module dds_phase_acc #(
  parameter int N = dds_pkg::PHASE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] inc,
  output logic [N-1:0] phase
);

  // Accumulate modulo 2^N; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + inc;
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer (start/stop/step/dwell) owning the DDS phase accumulator.
// Latency: start at cycle k gives busy/ftw=f_start/phase=0 at k+1; outputs all registered.
// Backpressure: none; start is only honoured in IDLE, abort ends a sweep the next cycle.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int N  = PHASE_W,
  parameter int DW = DWELL_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [N-1:0]  f_start,
  input  logic [N-1:0]  f_stop,
  input  logic [N-1:0]  f_step,
  input  logic [DW-1:0] dwell,
  output logic [N-1:0]  phase,
  output logic [N-1:0]  ftw,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  state_t        state;
  logic [DW-1:0] cnt;
  logic [N-1:0]  fs_q;
  logic [N-1:0]  fe_q;
  logic [N-1:0]  st_q;
  logic [DW-1:0] dw_q;
  logic          md_q;

  logic          cfg_ok;
  logic          accept;
  logic          acc_en;
  logic [N:0]    nxt;

  // A zero step would never terminate; an inverted range has no valid first word.
  assign cfg_ok = (f_step != '0) && (f_start <= f_stop);
  assign accept = (state == IDLE) && start && !abort && cfg_ok;
  // Abort freezes the phase in the same cycle it is seen.
  assign acc_en = (state == RUN) && !abort;
  // One extra bit so a step past 2^N-1 ends the sweep instead of wrapping.
  assign nxt    = {1'b0, ftw} + {1'b0, st_q};

  dds_phase_acc #(.N(N)) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (acc_en),
    .inc   (ftw),
    .phase (phase)
  );

  // Sweep FSM: config latch, dwell counting, tuning-word stepping and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ftw     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      fs_q    <= '0;
      fe_q    <= '0;
      st_q    <= '0;
      dw_q    <= '0;
      md_q    <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (cfg_ok) begin
              fs_q  <= f_start;
              fe_q  <= f_stop;
              st_q  <= f_step;
              dw_q  <= dwell;
              md_q  <= mode;
              ftw   <= f_start;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            ftw   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == dw_q) begin
            cnt <= '0;
            if (nxt <= {1'b0, fe_q}) begin
              ftw <= nxt[N-1:0];
            end else if (md_q) begin
              ftw <= fs_q;
            end else begin
              state <= DONE;
              ftw   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ftw   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: sweep-list reference model plus literal pins.
// Latency: model outputs are compared every cycle on the falling edge.
// Backpressure: n/a.
module tb_dds_sweep_ctrl;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int MODN = 1 << N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mode = 1'b0;
  logic [N-1:0]  f_start = '0;
  logic [N-1:0]  f_stop = '0;
  logic [N-1:0]  f_step = '0;
  logic [DW-1:0] dwell = '0;
  logic [N-1:0]  phase;
  logic [N-1:0]  ftw;
  logic          busy;
  logic          done;
  logic          cfg_err;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.N(N), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .f_start (f_start),
    .f_stop  (f_stop),
    .f_step  (f_step),
    .dwell   (dwell),
    .phase   (phase),
    .ftw     (ftw),
    .busy    (busy),
    .done    (done),
    .cfg_err (cfg_err)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a sweep is the list of tuning words, one entry per output cycle.
  int m_phase = 0;
  int m_ftw = 0;
  bit m_busy = 0;
  bit m_done = 0;
  bit m_cfg = 0;
  bit m_indone = 0;
  int q[$];
  int l_fs, l_fe, l_st, l_dw;
  bit l_md;

  function automatic void build_sweep();
    q.delete();
    for (int f = l_fs; f <= l_fe; f += l_st)
      for (int r = 0; r <= l_dw; r++)
        q.push_back(f);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_ftw = 0; m_busy = 0; m_done = 0; m_cfg = 0; m_indone = 0;
      q.delete();
    end else begin
      m_done = 0;
      m_cfg  = 0;
      if (m_indone) begin
        m_indone = 0;
      end else if (!m_busy) begin
        if (start && !abort) begin
          if (f_step != 0 && f_start <= f_stop) begin
            l_fs = f_start; l_fe = f_stop; l_st = f_step; l_dw = dwell; l_md = mode;
            build_sweep();
            m_busy  = 1;
            m_phase = 0;
            m_ftw   = q.pop_front();
          end else begin
            m_cfg = 1;
          end
        end
      end else if (abort) begin
        m_busy = 0;
        m_ftw  = 0;
        q.delete();
      end else begin
        m_phase = (m_phase + m_ftw) % MODN;
        if (q.size() == 0 && l_md) build_sweep();
        if (q.size() > 0) begin
          m_ftw = q.pop_front();
        end else begin
          m_busy = 0; m_indone = 1; m_done = 1; m_ftw = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("phase", int'(phase), m_phase);
      chk("ftw", int'(ftw), m_ftw);
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("cfg_err", int'(cfg_err), int'(m_cfg));
    end
  end

  // Called at a falling edge with the DUT idle; returns at the falling edge after acceptance.
  task automatic go(input int fs, input int fe, input int st, input int dw, input bit md);
    f_start = N'(fs); f_stop = N'(fe); f_step = N'(st); dwell = DW'(dw); mode = md;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    f_start = N'($urandom_range(0, MODN - 1));
    f_stop  = N'($urandom_range(0, MODN - 1));
    f_step  = N'($urandom_range(0, 15));
    dwell   = DW'($urandom_range(0, 3));
    mode    = 1'($urandom_range(0, 1));
  endtask

  int e1f[6] = '{4, 4, 8, 8, 12, 12};
  int e1p[6] = '{0, 4, 8, 16, 24, 36};
  int e2p[4] = '{0, 600, 176, 776};

  initial begin
    int fs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_ftw", int'(ftw), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single sweep with hand-computed sequence.
    go(4, 12, 4, 1, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t1_ftw", int'(ftw), e1f[i]);
      chk("t1_ftw_model", m_ftw, e1f[i]);
      chk("t1_phase", int'(phase), e1p[i]);
      chk("t1_phase_model", m_phase, e1p[i]);
      chk("t1_busy", int'(busy), 1);
      @(negedge clk);
    end
    chk("t1_done", int'(done), 1);
    chk("t1_done_busy", int'(busy), 0);
    chk("t1_done_ftw", int'(ftw), 0);
    @(negedge clk);
    chk("t1_done_clear", int'(done), 0);

    // Phase wrap-around.
    go(600, 600, 1, 3, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_phase", int'(phase), e2p[i]);
      chk("t2_phase_model", m_phase, e2p[i]);
      @(negedge clk);
    end
    chk("t2_done", int'(done), 1);
    @(negedge clk);

    // Back-to-back start in the cycle after done; repeat mode then abort.
    go(10, 20, 10, 0, 1);
    for (int i = 0; i < 7; i++) begin
      chk("t3_ftw", int'(ftw), (i % 2 == 0) ? 10 : 20);
      chk("t3_no_done", int'(done), 0);
      if (i < 6) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_abort_busy", int'(busy), 0);
    chk("t3_abort_ftw", int'(ftw), 0);
    chk("t3_abort_phase", int'(phase), 90);
    chk("t3_abort_done", int'(done), 0);
    @(negedge clk);

    // Step overflow ends the sweep instead of wrapping.
    go(1020, 1023, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t4_ftw", int'(ftw), 1020 + i);
      @(negedge clk);
    end
    chk("t4_done", int'(done), 1);
    chk("t4_done_ftw", int'(ftw), 0);
    @(negedge clk);
    chk("t4_phase_held", int'(phase), 1014);

    // Config errors: zero step, inverted range.
    go(10, 20, 0, 0, 0);
    chk("t5a_cfg_err", int'(cfg_err), 1);
    chk("t5a_busy", int'(busy), 0);
    chk("t5a_phase", int'(phase), 1014);
    @(negedge clk);
    chk("t5a_cfg_clear", int'(cfg_err), 0);
    go(50, 40, 1, 0, 0);
    chk("t5b_cfg_err", int'(cfg_err), 1);
    chk("t5b_busy", int'(busy), 0);
    chk("t5b_phase", int'(phase), 1014);
    @(negedge clk);

    // start and abort together in IDLE: no action.
    f_start = 5; f_stop = 9; f_step = 1; dwell = 0; mode = 0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_ftw", int'(ftw), 0);
    chk("t6_phase", int'(phase), 1014);

    // Reset mid-sweep, then a fresh start.
    go(0, 100, 1, 2, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7_phase", int'(phase), 0);
    chk("t7_ftw", int'(ftw), 0);
    chk("t7_busy", int'(busy), 0);
    chk("t7_done", int'(done), 0);
    go(100, 110, 5, 0, 0);
    chk("t8_busy", int'(busy), 1);
    chk("t8_ftw", int'(ftw), 100);
    chk("t8_phase", int'(phase), 0);
    repeat (6) @(negedge clk);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 63) == 0);
      mode  = 1'($urandom_range(0, 1));
      fs    = $urandom_range(0, MODN - 1);
      f_start = N'(fs);
      if ($urandom_range(0, 9) == 0)
        f_stop = N'($urandom_range(0, MODN - 1));
      else
        f_stop = N'((fs + $urandom_range(0, 40) > MODN - 1) ? MODN - 1 : fs + $urandom_range(0, 40));
      f_step = N'($urandom_range(0, 16));
      dwell  = DW'($urandom_range(0, 3));
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep controller for the direct digital synthesizer. It sequences the tuning word through a programmed linear ramp (start, stop, step, dwell) and owns the phase accumulator. Its registered phase output drives the phase-to-amplitude lookup directly. A single start pulse runs one sweep, or repeats it continuously, with done and config-error status.

## Interface

Parameters:
- N, 10: phase and tuning-word width; must match the amplitude LUT phase width.
- DW, 16: dwell counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  sweep request; sampled only in IDLE.
- abort  in  1  stop the sweep immediately.
- mode  in  1  0 = single sweep, 1 = repeat until abort.
- f_start  in  N  first tuning word.
- f_stop  in  N  last allowed tuning word, inclusive.
- f_step  in  N  tuning-word increment per step.
- dwell  in  DW  cycles per frequency, minus 1.
- phase  out  N  accumulated phase to the LUT.
- ftw  out  N  current tuning word.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of a single sweep.
- cfg_err  out  1  one-cycle pulse when start is rejected.

## Operation

- States: IDLE, RUN, DONE.
- Reset values: state IDLE; phase, ftw and the dwell counter 0; busy, done and cfg_err 0.
- IDLE, start=1 with valid config (f_step != 0 and f_start <= f_stop):
  - latch f_start, f_stop, f_step, dwell and mode;
  - next cycle: state RUN, ftw=f_start, phase=0, dwell counter=0.
- IDLE, start=1 with invalid config:
  - cfg_err=1 for one cycle;
  - state stays IDLE; nothing else changes.
- RUN, each cycle:
  - phase <= phase + ftw, mod 2^N (wraps silently);
  - the dwell counter increments.
- RUN, when the dwell counter equals the latched dwell (dwell+1 cycles at each ftw):
  - counter returns to 0;
  - next = ftw + f_step, computed in N+1 bits so there is no overflow;
  - if next <= f_stop: ftw <= next;
  - else if mode=1: ftw <= f_start;
  - else: state goes to DONE.
- DONE: done=1 for this cycle only; ftw=0; phase holds; then IDLE.
- abort=1 in RUN:
  - next cycle IDLE, ftw=0, phase holds;
  - no done pulse.
- Priority: rst > abort > start.
  - abort and start together in IDLE: no action.
  - start during RUN or DONE: ignored.
- Configuration inputs are ignored outside the IDLE start cycle.

## Timing

- All outputs are registered; no combinational input-to-output paths.
- Latency:
  - start in cycle k gives busy=1, ftw=f_start, phase=0 in cycle k+1;
  - the phase advance by f_start is visible at k+2.
- Single-sweep length: S = floor((f_stop - f_start)/f_step) + 1 steps.
  - RUN lasts S*(dwell+1) cycles.
  - The done pulse follows in the next cycle, with busy=0 in that cycle.
- Back-to-back sweeps: a start asserted in the cycle after DONE is accepted.
- Reset mid-sweep: state is IDLE in the next cycle with reset values; no done pulse.

## Structure

- Package dds_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default widths PHASE_W=10 and DWELL_W=16, shared with the LUT and the top level.
- Sub-module dds_phase_acc: N-bit registered accumulator with clear and enable inputs.
  - The FSM drives clear on sweep start and enable in RUN.
- FSM, dwell counter, config latch and step arithmetic stay in dds_sweep_ctrl.

## Test plan

- Single sweep: f_start=4, f_stop=12, f_step=4, dwell=1, mode=0.
  - ftw: 4,4,8,8,12,12; phase: 0,4,8,16,24,36.
  - Then done=1 once with busy=0, then IDLE.
- Wrap-around: f_start=f_stop=600, f_step=1, dwell=3.
  - phase: 0,600,176,776; done on the fifth cycle after busy rises.
- Repeat mode: f_start=10, f_stop=20, f_step=10, dwell=0, mode=1.
  - ftw: 10,20,10,20,... with no done pulse.
  - abort in the 7th RUN cycle gives IDLE next cycle, ftw=0, phase held.
- Step overflow: f_start=1020, f_stop=1023, f_step=1, dwell=0.
  - ftw: 1020..1023; next=1024 ends the sweep and done pulses; no wrap to 0.
- Config error: f_step=0, and separately f_start=50 with f_stop=40.
  - Each gives cfg_err=1 for one cycle, busy stays 0, phase unchanged.
- Priority and reset:
  - start and abort together in IDLE: nothing happens.
  - rst asserted mid-RUN: all outputs 0 in the next cycle.
  - A new start is then accepted normally.
